input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Conditions the asynchronous board inputs (5 switches, IR receiver output) before they
//   reach the CPU's memory-mapped input decoder.
//   - Per-bit synchronizer and counter-based debouncer.
//   - Edge detection on the IR line, plus a sticky IR event flag that firmware clears.
//   Sits between the top-level pins and the core's sw/IR inputs; all outputs are clk-domain levels.
// PARAMETERS
//   SW_W        5   number of switch inputs
//   SYNC_STAGES 2   synchronizer flops per input (legal >= 2)
//   DB_CYCLES   16  consecutive stable synchronized samples required to accept a change (legal >= 2)
//   CNT_W       $clog2(DB_CYCLES)  debounce counter width (derived, localparam)
// PORTS
//   clk       in   1     system clock, single domain
//   reset     in   1     synchronous, active-high reset
//   sw_raw    in   SW_W  asynchronous switch pins
//   ir_raw    in   1     asynchronous IR receiver pin
//   ev_clr    in   1     clears ir_event (firmware write strobe)
//   sw_db     out  SW_W  debounced switch levels -> core sw
//   ir_db     out  1     debounced IR level -> core IR
//   ir_rise   out  1     one-cycle pulse on ir_db 0->1
//   ir_fall   out  1     one-cycle pulse on ir_db 1->0
//   ir_event  out  1     sticky: set by ir_rise, cleared by ev_clr
// BEHAVIOUR
//   Reset (clk edge with reset=1):
//   - Sync flops, debounce counters, sw_db, ir_db, edge-history flops and ir_event all go to 0.
//   - ir_rise and ir_fall are 0 while reset is held and in the first cycle after reset.
//   - Reset mid-debounce discards the count; no partial state survives.
//   Synchronizer: SYNC_STAGES-flop shift per bit; s = last stage. No logic between stages.
//   Debounce cell, per bit, each edge:
//   - If s == db: cnt <= 0.
//   - Else if cnt == DB_CYCLES-1: db <= s, cnt <= 0.
//   - Else: cnt <= cnt+1.
//   Latency:
//   - Number edges from 1, where edge 1 is the first edge that samples the new stable raw value.
//   - db updates on edge SYNC_STAGES+DB_CYCLES (18 at defaults).
//   Glitch rejection:
//   - s differing for fewer than DB_CYCLES consecutive samples never changes db.
//   - The counter returns to 0 on the first sample matching db.
//   - Bouncing restarts the count; there is no accumulation across bounces.
//   Edge detect: ir_q <= ir_db each edge.
//   - ir_rise = ir_db & ~ir_q; ir_fall = ~ir_db & ir_q.
//   - Each is high exactly the one cycle after ir_db changes.
//   ir_event, each edge:
//   - ir_event <= ir_rise | (ir_event & ~ev_clr).
//   - ir_rise and ev_clr in the same cycle: set wins, ir_event stays 1.
//   - ev_clr with no event: no effect.
//   Input high at reset release:
//   - db reaches 1 after the normal latency, counted from the first post-reset edge.
//   - For IR this produces one ir_rise and sets ir_event. This is required behaviour.
//   Counter never exceeds DB_CYCLES-1; no wrap. All bits are independent.
//   Switch bits have no edge/event logic.
// STRUCTURE
//   Shared package input_pkg:
//   - SW_W_DEF = 5, SYNC_STAGES_DEF = 2, DB_CYCLES_DEF = 16.
//   - Names of the event-clear address constant used by the decoder.
//   Sub-module debounce_cell (params SYNC_STAGES, DB_CYCLES; ports clk, reset, raw, db):
//   - Instantiated SW_W+1 times via generate.
//   - Edge detect and ir_event live in the top.
// TESTING (bench uses DB_CYCLES=4, SYNC_STAGES=2)
//   1. Reset with sw_raw=5'b10101, ir_raw=0; release -> sw_db=0 until edge 6, then 5'b10101;
//      ir_db, ir_event stay 0.
//   2. ir_raw 0->1 held -> ir_db=1 at edge 6; ir_rise=1 for exactly one cycle after;
//      ir_event=1 and stays 1.
//   3. ir_raw pulses 1 for 3 cycles, then 0 (with ir_db=0) -> ir_db, ir_rise, ir_event unchanged.
//      Bouncing 1,1,0,1,1,1,1 -> ir_db rises 6 edges after the final 0->1.
//   4. ev_clr asserted in the same cycle as ir_rise -> ir_event=1.
//      ev_clr next cycle (no rise) -> ir_event=0 on that edge.
//   5. ir_db=1, ir_raw 1->0 -> ir_fall one-cycle pulse; ir_event unaffected.
//      reset asserted at count 2 of a pending change -> everything 0, no late update.
//   6. Random async toggling on all sw bits with a checker model -> sw_db matches the model
//      every cycle; no output changes during stable-input windows.

Source files
------------

// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
//   Shared definitions for the board-input conditioning path.
//   - Default parameter values used by input_conditioner and debounce_cell.
//   - Register map of the memory-mapped input decoder. The event-clear address
//     is named here so the decoder and the conditioner agree on it.
//   - Helper to size the debounce counter.
// -----------------------------------------------------------------------------
package input_pkg;

    // Default build parameters
    localparam int SW_W_DEF        = 5;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 16;

    // Input decoder register map (word offsets inside the input block)
    localparam int IN_ADDR_W = 4;

    typedef enum logic [IN_ADDR_W-1:0] {
        IN_REG_SW     = 4'h0,   // read: debounced switch levels
        IN_REG_IR     = 4'h1,   // read: debounced IR level
        IN_REG_EVENT  = 4'h2,   // read: sticky IR event flag
        IN_REG_EV_CLR = 4'h3    // write: clear IR event flag
    } in_reg_e;

    // Address the decoder compares against to produce the ev_clr strobe
    localparam logic [IN_ADDR_W-1:0] EV_CLR_ADDR = IN_REG_EV_CLR;

    // Counter width needed to hold 0 .. n-1. Legal n is >= 2, so $clog2(n)
    // is always at least 1; the guard only protects against misuse.
    function automatic int db_cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : input_pkg

// File: rtl/debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
//   One-bit synchronizer followed by a counter-based debouncer.
//   The synchronizer is a plain SYNC_STAGES-deep shift register with no logic
//   between stages. The debounced level only follows the synchronized sample
//   once that sample has disagreed with it for DB_CYCLES consecutive clocks.
//
// Parameters
//   SYNC_STAGES  synchronizer depth (>= 2)
//   DB_CYCLES    consecutive differing samples needed to accept a change (>= 2)
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   raw    in   asynchronous input pin
//   db     out  debounced level, clk domain
// -----------------------------------------------------------------------------
module debounce_cell
    import input_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int                CNT_W   = db_cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   w_s;

    // Synchronizer: raw enters at bit 0, the last stage is the usable sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Debouncer. Any sample that agrees with the current level drops the count
    // back to zero, so bounces restart the qualification window instead of
    // accumulating. The counter tops out at CNT_MAX and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_db  <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign db = r_db;

endmodule : debounce_cell

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Conditions the asynchronous board inputs (switches and IR receiver) before
//   they reach the CPU's memory-mapped input decoder. Every input gets its own
//   synchronizer + debouncer; the IR line additionally gets edge pulses and a
//   sticky event flag that firmware clears through the ev_clr strobe.
//
// Parameters
//   SW_W         number of switch inputs
//   SYNC_STAGES  synchronizer flops per input (>= 2)
//   DB_CYCLES    consecutive stable samples required to accept a change (>= 2)
//
// Ports
//   clk       in   system clock, single domain
//   reset     in   synchronous active-high reset
//   sw_raw    in   asynchronous switch pins [SW_W]
//   ir_raw    in   asynchronous IR receiver pin
//   ev_clr    in   firmware strobe clearing ir_event
//   sw_db     out  debounced switch levels [SW_W]
//   ir_db     out  debounced IR level
//   ir_rise   out  one-cycle pulse after ir_db goes 0->1
//   ir_fall   out  one-cycle pulse after ir_db goes 1->0
//   ir_event  out  sticky flag, set by ir_rise, cleared by ev_clr
// -----------------------------------------------------------------------------
module input_conditioner
    import input_pkg::*;
#(
    parameter int SW_W        = SW_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            ir_raw,
    input  logic            ev_clr,
    output logic [SW_W-1:0] sw_db,
    output logic            ir_db,
    output logic            ir_rise,
    output logic            ir_fall,
    output logic            ir_event
);

    // The IR pin rides along as the top bit so every input uses the same cell.
    localparam int N_IN = SW_W + 1;

    logic [N_IN-1:0] w_raw_all;
    logic [N_IN-1:0] w_db_all;
    logic            w_ir_db;
    logic            w_ir_rise;
    logic            w_ir_fall;
    logic            r_ir_q;
    logic            r_ir_event;

    assign w_raw_all = {ir_raw, sw_raw};

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cell
            debounce_cell #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .raw   (w_raw_all[gi]),
                .db    (w_db_all[gi])
            );
        end
    endgenerate

    assign w_ir_db = w_db_all[SW_W];

    // Edge history for the debounced IR level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q <= 1'b0;
        end else begin
            r_ir_q <= w_ir_db;
        end
    end

    // Both ir_db and r_ir_q are cleared by reset, so the pulses are already
    // zero in the cycle after reset; the explicit gate also keeps them low
    // while reset is being held, before the first reset edge has landed.
    assign w_ir_rise = ~reset &  w_ir_db & ~r_ir_q;
    assign w_ir_fall = ~reset & ~w_ir_db &  r_ir_q;

    // Sticky event. A rise in the same cycle as a clear wins, so firmware
    // that clears late never loses a fresh event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_event <= 1'b0;
        end else begin
            r_ir_event <= w_ir_rise | (r_ir_event & ~ev_clr);
        end
    end

    assign sw_db    = w_db_all[SW_W-1:0];
    assign ir_db    = w_ir_db;
    assign ir_rise  = w_ir_rise;
    assign ir_fall  = w_ir_fall;
    assign ir_event = r_ir_event;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Directed bench for input_conditioner built with DB_CYCLES=4, SYNC_STAGES=2,
//   giving a raw-to-debounced latency of 6 edges. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int SW_W = 5;
    localparam int LAT  = 6;

    logic            clk;
    logic            reset;
    logic [SW_W-1:0] sw_raw;
    logic            ir_raw;
    logic            ev_clr;
    logic [SW_W-1:0] sw_db;
    logic            ir_db;
    logic            ir_rise;
    logic            ir_fall;
    logic            ir_event;

    int n_tests;
    int n_fail;

    input_conditioner #(
        .SW_W        (SW_W),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .ir_raw   (ir_raw),
        .ev_clr   (ev_clr),
        .sw_db    (sw_db),
        .ir_db    (ir_db),
        .ir_rise  (ir_rise),
        .ir_fall  (ir_fall),
        .ir_event (ir_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = 5'b10101;
        ir_raw = 1'b0;
        ev_clr = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if ({sw_db, ir_db, ir_rise, ir_fall, ir_event} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: got sw_db=%b ir_db=%b rise=%b fall=%b event=%b, want all 0",
                     sw_db, ir_db, ir_rise, ir_fall, ir_event);
        end
        reset = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            n_tests++;
            if (sw_db !== ((e == LAT) ? 5'b10101 : 5'b00000)) begin
                n_fail++;
                $display("FAIL reset_release_sw edge %0d: got sw_db=%b want %b", e, sw_db,
                         (e == LAT) ? 5'b10101 : 5'b00000);
            end
            n_tests++;
            if ({ir_db, ir_rise, ir_event} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_release_ir edge %0d: got ir_db=%b rise=%b event=%b want 000",
                         e, ir_db, ir_rise, ir_event);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_rise();
        ir_raw = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            n_tests++;
            if (ir_db !== (e == LAT)) begin
                n_fail++;
                $display("FAIL rise_latency edge %0d: got ir_db=%b want %b", e, ir_db, e == LAT);
            end
        end
        n_tests++;
        if (ir_rise !== 1'b1 || ir_event !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_pulse: got rise=%b event=%b want rise=1 event=0", ir_rise, ir_event);
        end
        tick();
        n_tests++;
        if (ir_rise !== 1'b0 || ir_event !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_after: got rise=%b event=%b want rise=0 event=1", ir_rise, ir_event);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (ir_event !== 1'b1 || ir_rise !== 1'b0) begin
                n_fail++;
                $display("FAIL event_sticky cycle %0d: got event=%b rise=%b want 1/0", i, ir_event, ir_rise);
            end
        end
        $display("[TB] test_rise done");
    endtask

    task automatic test_glitch();
        logic seq [9];
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        reset  = 1'b1;
        ir_raw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        // Three-sample pulse: must be rejected.
        for (int i = 0; i < 11; i++) begin
            ir_raw = (i < 3);
            tick();
            n_tests++;
            if ({ir_db, ir_rise, ir_event} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_reject cycle %0d: got ir_db=%b rise=%b event=%b want 000",
                         i, ir_db, ir_rise, ir_event);
            end
        end
        // Bounce 1,1,0 then stable 1: db rises on the 6th edge after the last 0->1.
        for (int i = 0; i < 9; i++) begin
            ir_raw = seq[i];
            tick();
            n_tests++;
            if (ir_db !== (i == 8) || ir_rise !== (i == 8)) begin
                n_fail++;
                $display("FAIL bounce edge %0d: got ir_db=%b rise=%b want %b", i + 1, ir_db, ir_rise, i == 8);
            end
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_fall();
        tick();
        ir_raw = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            n_tests++;
            if (ir_db !== (e != LAT) || ir_fall !== (e == LAT)) begin
                n_fail++;
                $display("FAIL fall edge %0d: got ir_db=%b fall=%b want ir_db=%b fall=%b",
                         e, ir_db, ir_fall, e != LAT, e == LAT);
            end
        end
        tick();
        n_tests++;
        if (ir_fall !== 1'b0 || ir_event !== 1'b1 || ir_rise !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_after: got fall=%b rise=%b event=%b want 0/0/1", ir_fall, ir_rise, ir_event);
        end
        $display("[TB] test_fall done");
    endtask

    task automatic test_event_clear();
        ev_clr = 1'b1;
        tick();
        ev_clr = 1'b0;
        n_tests++;
        if (ir_event !== 1'b0) begin
            n_fail++;
            $display("FAIL ev_clr: got event=%b want 0", ir_event);
        end
        ev_clr = 1'b1;
        tick();
        ev_clr = 1'b0;
        n_tests++;
        if (ir_event !== 1'b0) begin
            n_fail++;
            $display("FAIL ev_clr_idle: got event=%b want 0", ir_event);
        end
        ir_raw = 1'b1;
        for (int e = 1; e <= LAT; e++) tick();
        n_tests++;
        if (ir_rise !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_rise_setup: got rise=%b want 1", ir_rise);
        end
        ev_clr = 1'b1;
        tick();
        n_tests++;
        if (ir_event !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got event=%b want 1", ir_event);
        end
        tick();
        ev_clr = 1'b0;
        n_tests++;
        if (ir_event !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_next: got event=%b want 0", ir_event);
        end
        $display("[TB] test_event_clear done");
    endtask

    task automatic test_reset_mid();
        ir_raw = 1'b0;
        for (int e = 1; e <= LAT; e++) tick();
        n_tests++;
        if (ir_db !== 1'b0 || ir_event !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_setup: got ir_db=%b event=%b want 0/0", ir_db, ir_event);
        end
        ir_raw = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        reset  = 1'b1;
        ir_raw = 1'b0;
        tick();
        n_tests++;
        if ({sw_db, ir_db, ir_rise, ir_fall, ir_event} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got sw_db=%b ir_db=%b rise=%b fall=%b event=%b want all 0",
                     sw_db, ir_db, ir_rise, ir_fall, ir_event);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if ({ir_db, ir_rise, ir_event} !== 3'b000) begin
                n_fail++;
                $display("FAIL no_late_update cycle %0d: got ir_db=%b rise=%b event=%b want 000",
                         i, ir_db, ir_rise, ir_event);
            end
        end
        ir_raw = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            n_tests++;
            if (ir_db !== (e == LAT)) begin
                n_fail++;
                $display("FAIL full_latency edge %0d: got ir_db=%b want %b", e, ir_db, e == LAT);
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random_sw();
        logic [SW_W-1:0] m_s0, m_s1, m_db;
        int              m_cnt [SW_W];
        reset  = 1'b1;
        ir_raw = 1'b0;
        ev_clr = 1'b0;
        sw_raw = '0;
        tick();
        tick();
        reset = 1'b0;
        m_s0  = '0;
        m_s1  = '0;
        m_db  = '0;
        for (int b = 0; b < SW_W; b++) m_cnt[b] = 0;
        for (int blk = 0; blk < 16; blk++) begin
            for (int c = 0; c < 22; c++) begin
                if (c < 12 && $urandom_range(0, 1) == 1) begin
                    sw_raw = sw_raw ^ SW_W'($urandom_range(0, 31));
                end
                tick();
                // Reference debouncer: counter input is the raw value from two edges back.
                for (int b = 0; b < SW_W; b++) begin
                    if (m_s1[b] == m_db[b]) begin
                        m_cnt[b] = 0;
                    end else if (m_cnt[b] == 3) begin
                        m_db[b]  = m_s1[b];
                        m_cnt[b] = 0;
                    end else begin
                        m_cnt[b] = m_cnt[b] + 1;
                    end
                end
                m_s1 = m_s0;
                m_s0 = sw_raw;
                n_tests++;
                if (sw_db !== m_db || ir_db !== 1'b0 || ir_event !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_sw blk %0d cyc %0d: got sw_db=%b ir_db=%b event=%b want %b/0/0",
                             blk, c, sw_db, ir_db, ir_event, m_db);
                end
            end
            n_tests++;
            if (sw_db !== sw_raw) begin
                n_fail++;
                $display("FAIL stable_window blk %0d: got sw_db=%b want %b", blk, sw_db, sw_raw);
            end
        end
        $display("[TB] test_random_sw done");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        sw_raw  = '0;
        ir_raw  = 1'b0;
        ev_clr  = 1'b0;
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_event_clear();
        test_reset_mid();
        test_random_sw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_input_conditioner
